// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: entry geometry, physical
// register width and the bit offsets of the three completion lanes.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_W     = 5;
  localparam int ROB_CNT_W = ROB_W + 1;
  localparam int PR_ADDR_W = 6;
  localparam int ARCH_W    = 4;
  localparam int ADDR_W    = 16;

  // Lane positions inside ROB_entries_in: {arith, mem, term}
  localparam int LANE_ARITH_LSB = 10;
  localparam int LANE_MEM_LSB   = 5;
  localparam int LANE_TERM_LSB  = 0;

  typedef struct packed {
    logic [2*ARCH_W-1:0]    arch;
    logic [2*PR_ADDR_W-1:0] phys;
    logic [2*PR_ADDR_W-1:0] old_phys;
    logic [1:0]             mask;
  } rob_op_t;

  function automatic logic [ROB_W-1:0] lane_index(input logic [3*ROB_W-1:0] entries,
                                                  input int lsb);
    return entries[lsb +: ROB_W];
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping head/tail pointers and occupancy count for the reorder buffer.
// A flush empties the buffer just past the retiring head.
module reorder_buffer_rob_ptr
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_head,
  input  logic                 inc_tail,
  input  logic                 flush,
  output logic [ROB_W-1:0]     head,
  output logic [ROB_CNT_W-1:0] count,
  output logic [ROB_W-1:0]     tail
);

  logic [ROB_W-1:0]     head_r;
  logic [ROB_W-1:0]     tail_r;
  logic [ROB_CNT_W-1:0] count_r;
  logic [ROB_W-1:0]     head_nxt_s;
  logic [ROB_W-1:0]     tail_nxt_s;
  logic [ROB_CNT_W-1:0] count_nxt_s;

  // Next pointer values; pointers wrap naturally at the power-of-two depth
  always_comb begin
    head_nxt_s  = head_r + ROB_W'(inc_head);
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (flush) begin
      tail_nxt_s  = head_nxt_s;
      count_nxt_s = {ROB_CNT_W{1'b0}};
    end else begin
      tail_nxt_s  = tail_r + ROB_W'(inc_tail);
      count_nxt_s = count_r + ROB_CNT_W'(inc_tail) - ROB_CNT_W'(inc_head);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {ROB_W{1'b0}};
      tail_r  <= {ROB_W{1'b0}};
      count_r <= {ROB_CNT_W{1'b0}};
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign head  = head_r;
  assign tail  = tail_r;
  assign count = count_r;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates renamed ops at the tail, collects
// out-of-order completions from three lanes, retires one op per cycle at the head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [2*ARCH_W-1:0]    alloc_arch_regs,
  input  logic [2*PR_ADDR_W-1:0] alloc_phys_regs,
  input  logic [2*PR_ADDR_W-1:0] alloc_old_phys,
  input  logic [1:0]             alloc_dest_mask,
  output logic [ROB_W-1:0]       alloc_entry,
  input  logic                   complete_arith_valid,
  input  logic                   complete_mem_valid,
  input  logic [3*ROB_W-1:0]     ROB_entries_in,
  input  logic                   complete_term_valid,
  output logic                   complete_term_ready,
  input  logic                   complete_term_failed,
  input  logic [ADDR_W-1:0]      term_address,
  output logic                   commit_valid,
  output logic [2*ARCH_W-1:0]    commit_arch_regs,
  output logic [2*PR_ADDR_W-1:0] commit_phys_regs,
  output logic [2*PR_ADDR_W-1:0] commit_free_regs,
  output logic [1:0]             commit_dest_mask,
  output logic                   flush,
  output logic [ADDR_W-1:0]      redirect_addr
);

  logic [ROB_W-1:0]     head_s;
  logic [ROB_W-1:0]     tail_s;
  logic [ROB_CNT_W-1:0] count_s;

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] done_r;
  logic [DEPTH-1:0] failed_r;
  rob_op_t          op_r   [DEPTH];
  logic [ADDR_W-1:0] addr_r [DEPTH];

  logic             commit_s;
  logic             flush_s;
  logic             not_full_s;
  logic             alloc_fire_s;
  logic             arith_hit_s;
  logic             mem_hit_s;
  logic             term_hit_s;
  logic [ROB_W-1:0] arith_idx_s;
  logic [ROB_W-1:0] mem_idx_s;
  logic [ROB_W-1:0] term_idx_s;

  reorder_buffer_rob_ptr u_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_head (commit_s),
    .inc_tail (alloc_fire_s),
    .flush    (flush_s),
    .head     (head_s),
    .count    (count_s),
    .tail     (tail_s)
  );

  // Retirement, flush and handshake decisions from registered state
  always_comb begin
    commit_s = 1'b0;
    flush_s  = 1'b0;
    if ((count_s != {ROB_CNT_W{1'b0}}) && valid_r[head_s] && done_r[head_s]) begin
      commit_s = 1'b1;
      flush_s  = failed_r[head_s];
    end else begin
      commit_s = 1'b0;
      flush_s  = 1'b0;
    end
    not_full_s   = (count_s != ROB_CNT_W'(DEPTH));
    alloc_fire_s = alloc_valid && not_full_s && !flush_s;
    arith_idx_s  = lane_index(ROB_entries_in, LANE_ARITH_LSB);
    mem_idx_s    = lane_index(ROB_entries_in, LANE_MEM_LSB);
    term_idx_s   = lane_index(ROB_entries_in, LANE_TERM_LSB);
    // Strobes to empty slots are dropped; a flush discards everything younger
    arith_hit_s  = complete_arith_valid && valid_r[arith_idx_s];
    mem_hit_s    = complete_mem_valid && valid_r[mem_idx_s];
    term_hit_s   = complete_term_valid && !flush_s && valid_r[term_idx_s];
  end

  // Output drive; retirement data is forced to zero when nothing retires
  always_comb begin
    alloc_ready         = not_full_s && !flush_s;
    alloc_entry         = tail_s;
    complete_term_ready = !flush_s;
    commit_valid        = commit_s;
    flush               = flush_s;
    commit_arch_regs    = {(2*ARCH_W){1'b0}};
    commit_phys_regs    = {(2*PR_ADDR_W){1'b0}};
    commit_free_regs    = {(2*PR_ADDR_W){1'b0}};
    commit_dest_mask    = 2'b00;
    redirect_addr       = {ADDR_W{1'b0}};
    if (commit_s) begin
      commit_arch_regs = op_r[head_s].arch;
      commit_phys_regs = op_r[head_s].phys;
      commit_free_regs = op_r[head_s].old_phys;
      commit_dest_mask = op_r[head_s].mask;
    end else begin
      commit_dest_mask = 2'b00;
    end
    if (flush_s) begin
      redirect_addr = addr_r[head_s];
    end else begin
      redirect_addr = {ADDR_W{1'b0}};
    end
  end

  // Entry status flags; alloc is applied last so it overrides stale updates
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= {DEPTH{1'b0}};
      done_r   <= {DEPTH{1'b0}};
      failed_r <= {DEPTH{1'b0}};
    end else if (flush_s) begin
      valid_r  <= {DEPTH{1'b0}};
      done_r   <= {DEPTH{1'b0}};
      failed_r <= {DEPTH{1'b0}};
    end else begin
      if (arith_hit_s) begin
        done_r[arith_idx_s] <= 1'b1;
      end
      if (mem_hit_s) begin
        done_r[mem_idx_s] <= 1'b1;
      end
      if (term_hit_s) begin
        done_r[term_idx_s]   <= 1'b1;
        failed_r[term_idx_s] <= complete_term_failed;
      end
      if (commit_s) begin
        valid_r[head_s]  <= 1'b0;
        done_r[head_s]   <= 1'b0;
        failed_r[head_s] <= 1'b0;
      end
      if (alloc_fire_s) begin
        valid_r[tail_s]  <= 1'b1;
        done_r[tail_s]   <= 1'b0;
        failed_r[tail_s] <= 1'b0;
      end
    end
  end

  // Entry payload; only meaningful while the matching valid flag is set
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      op_r[tail_s]   <= '{arch: alloc_arch_regs, phys: alloc_phys_regs,
                          old_phys: alloc_old_phys, mask: alloc_dest_mask};
      addr_r[tail_s] <= {ADDR_W{1'b0}};
    end
    if (term_hit_s) begin
      addr_r[term_idx_s] <= term_address;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// all compared each cycle against a queue-of-ops reference model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [2*ARCH_W-1:0]    alloc_arch_regs;
  logic [2*PR_ADDR_W-1:0] alloc_phys_regs;
  logic [2*PR_ADDR_W-1:0] alloc_old_phys;
  logic [1:0]             alloc_dest_mask;
  logic [ROB_W-1:0]       alloc_entry;
  logic                   complete_arith_valid;
  logic                   complete_mem_valid;
  logic [3*ROB_W-1:0]     ROB_entries_in;
  logic                   complete_term_valid;
  logic                   complete_term_ready;
  logic                   complete_term_failed;
  logic [ADDR_W-1:0]      term_address;
  logic                   commit_valid;
  logic [2*ARCH_W-1:0]    commit_arch_regs;
  logic [2*PR_ADDR_W-1:0] commit_phys_regs;
  logic [2*PR_ADDR_W-1:0] commit_free_regs;
  logic [1:0]             commit_dest_mask;
  logic                   flush;
  logic [ADDR_W-1:0]      redirect_addr;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_arch_regs(alloc_arch_regs), .alloc_phys_regs(alloc_phys_regs),
    .alloc_old_phys(alloc_old_phys), .alloc_dest_mask(alloc_dest_mask),
    .alloc_entry(alloc_entry),
    .complete_arith_valid(complete_arith_valid), .complete_mem_valid(complete_mem_valid),
    .ROB_entries_in(ROB_entries_in),
    .complete_term_valid(complete_term_valid), .complete_term_ready(complete_term_ready),
    .complete_term_failed(complete_term_failed), .term_address(term_address),
    .commit_valid(commit_valid), .commit_arch_regs(commit_arch_regs),
    .commit_phys_regs(commit_phys_regs), .commit_free_regs(commit_free_regs),
    .commit_dest_mask(commit_dest_mask),
    .flush(flush), .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [7:0]  arch;
    logic [11:0] phys;
    logic [11:0] old;
    logic [1:0]  mask;
    bit          done;
    bit          failed;
    logic [15:0] addr;
  } op_t;

  op_t         q[$];
  int          commit_log[$];
  int          next_idx;
  int          checks;
  int          errors;
  int          flushes;
  logic [15:0] last_redirect;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void mark(input int idx, input bit term, input bit failed,
                               input logic [15:0] addr);
    foreach (q[i]) begin
      if (q[i].idx == idx) begin
        q[i].done = 1'b1;
        if (term) begin
          q[i].failed = failed;
          q[i].addr   = addr;
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    alloc_valid          = 1'b0;
    complete_arith_valid = 1'b0;
    complete_mem_valid   = 1'b0;
    complete_term_valid  = 1'b0;
    complete_term_failed = 1'b0;
    ROB_entries_in       = 15'd0;
    term_address         = 16'd0;
  endtask

  task automatic rand_payload();
    alloc_arch_regs = 8'($urandom);
    alloc_phys_regs = 12'($urandom);
    alloc_old_phys  = 12'($urandom);
    alloc_dest_mask = 2'($urandom);
  endtask

  // Check outputs for the current cycle, advance the model, then step the clock
  task automatic cycle();
    bit  ec;
    bit  ef;
    bit  fire;
    op_t h;
    op_t n;
    ec = (q.size() > 0) && q[0].done;
    ef = ec && q[0].failed;
    chk("alloc_ready", 32'(alloc_ready), 32'((q.size() < ROB_DEPTH) && !ef));
    chk("alloc_entry", 32'(alloc_entry), 32'(next_idx));
    chk("commit_valid", 32'(commit_valid), 32'(ec));
    chk("flush", 32'(flush), 32'(ef));
    chk("term_ready", 32'(complete_term_ready), 32'(!ef));
    if (ec) begin
      h = q[0];
      chk("commit_arch", 32'(commit_arch_regs), 32'(h.arch));
      chk("commit_phys", 32'(commit_phys_regs), 32'(h.phys));
      chk("commit_free", 32'(commit_free_regs), 32'(h.old));
      chk("commit_mask", 32'(commit_dest_mask), 32'(h.mask));
    end else begin
      chk("commit_zero", {commit_arch_regs, commit_phys_regs, commit_dest_mask}, 32'd0);
      chk("commit_free_zero", 32'(commit_free_regs), 32'd0);
    end
    if (ef) begin
      chk("redirect_addr", 32'(redirect_addr), 32'(h.addr));
      last_redirect = redirect_addr;
      flushes++;
    end
    fire = alloc_valid && (q.size() < ROB_DEPTH) && !ef;
    if (!ef) begin
      if (complete_arith_valid) mark(int'(ROB_entries_in[14:10]), 1'b0, 1'b0, 16'd0);
      if (complete_mem_valid)   mark(int'(ROB_entries_in[9:5]), 1'b0, 1'b0, 16'd0);
      if (complete_term_valid)  mark(int'(ROB_entries_in[4:0]), 1'b1,
                                     complete_term_failed, term_address);
    end
    if (ec) begin
      commit_log.push_back(h.idx);
      void'(q.pop_front());
    end
    if (ef) begin
      q.delete();
      next_idx = (h.idx + 1) % ROB_DEPTH;
    end else if (fire) begin
      n.idx = next_idx; n.arch = alloc_arch_regs; n.phys = alloc_phys_regs;
      n.old = alloc_old_phys; n.mask = alloc_dest_mask;
      n.done = 1'b0; n.failed = 1'b0; n.addr = 16'd0;
      q.push_back(n);
      next_idx = (next_idx + 1) % ROB_DEPTH;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    commit_log.delete();
    next_idx = 0;
    flushes  = 0;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_entry", 32'(alloc_entry), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect", 32'(redirect_addr), 32'd0);
    chk("rst_term_ready", 32'(complete_term_ready), 32'd1);
  endtask

  task automatic alloc_ops(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      alloc_valid = 1'b1;
      rand_payload();
      cycle();
    end
    idle_inputs();
  endtask

  // lane: 0 arith, 1 mem, 2 term
  task automatic complete_one(input int lane, input int idx, input bit failed,
                              input logic [15:0] addr);
    idle_inputs();
    case (lane)
      0: begin complete_arith_valid = 1'b1; ROB_entries_in[14:10] = 5'(idx); end
      1: begin complete_mem_valid = 1'b1; ROB_entries_in[9:5] = 5'(idx); end
      default: begin
        complete_term_valid = 1'b1; ROB_entries_in[4:0] = 5'(idx);
        complete_term_failed = failed; term_address = addr;
      end
    endcase
    cycle();
    idle_inputs();
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rand_payload();
    do_reset();

    // In-order retirement of out-of-order completions
    alloc_ops(3);
    idle_cycles(2);
    complete_one(0, 2, 1'b0, 16'd0);
    complete_one(1, 1, 1'b0, 16'd0);
    complete_one(2, 0, 1'b0, 16'h1234);
    idle_cycles(4);
    chk("order_len", 32'(commit_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < commit_log.size(); i++)
      chk("order_idx", 32'(commit_log[i]), 32'(i));

    // Fill to capacity, retire one, wrap the tail
    do_reset();
    alloc_ops(32);
    alloc_valid = 1'b1;
    chk("full_not_ready", 32'(alloc_ready), 32'd0);
    cycle();
    complete_one(0, 0, 1'b0, 16'd0);
    idle_inputs();
    chk("commit_at_full", 32'(commit_valid), 32'd1);
    cycle();
    chk("ready_after_commit", 32'(alloc_ready), 32'd1);
    chk("wrap_entry", 32'(alloc_entry), 32'd0);

    // Three lanes completing in one cycle
    do_reset();
    alloc_ops(7);
    idle_inputs();
    complete_arith_valid = 1'b1; complete_mem_valid = 1'b1; complete_term_valid = 1'b1;
    ROB_entries_in = {5'd4, 5'd5, 5'd6};
    term_address = 16'h0042;
    cycle();
    for (int i = 0; i < 4; i++) complete_one(i % 2, i, 1'b0, 16'd0);
    idle_cycles(8);
    chk("lanes_len", 32'(commit_log.size()), 32'd7);
    for (int i = 0; i < commit_log.size(); i++)
      chk("lanes_idx", 32'(commit_log[i]), 32'(i));

    // Mispredicted terminator flushes younger ops
    do_reset();
    alloc_ops(6);
    complete_one(2, 2, 1'b1, 16'hC000);
    complete_one(0, 0, 1'b0, 16'd0);
    complete_one(1, 1, 1'b0, 16'd0);
    idle_cycles(3);
    for (int i = 3; i < 6; i++) complete_one(0, i, 1'b0, 16'd0);
    idle_cycles(3);
    chk("flush_len", 32'(commit_log.size()), 32'd3);
    chk("flush_count", 32'(flushes), 32'd1);
    chk("flush_redirect", 32'(last_redirect), 32'h0000C000);
    chk("flush_next_entry", 32'(alloc_entry), 32'd3);

    // Strobe to an unallocated entry is ignored
    do_reset();
    complete_one(0, 9, 1'b0, 16'd0);
    alloc_ops(10);
    for (int i = 0; i < 9; i++) complete_one(0, i, 1'b0, 16'd0);
    idle_cycles(4);
    chk("stale_len", 32'(commit_log.size()), 32'd9);
    complete_one(1, 9, 1'b0, 16'd0);
    idle_cycles(2);
    chk("stale_len_after", 32'(commit_log.size()), 32'd10);

    // Reset with ops in flight
    do_reset();
    alloc_ops(10);
    complete_one(0, 3, 1'b0, 16'd0);
    complete_one(2, 4, 1'b1, 16'hBEEF);
    do_reset();
    idle_cycles(5);
    chk("midrst_commits", 32'(commit_log.size()), 32'd0);
    chk("midrst_flushes", 32'(flushes), 32'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      idle_inputs();
      alloc_valid = ($urandom % 3) != 0;
      rand_payload();
      if ($urandom % 2 == 1) begin
        complete_arith_valid = 1'b1;
        ROB_entries_in[14:10] = (q.size() > 0 && $urandom % 4 != 0) ?
                                5'(q[$urandom % q.size()].idx) : 5'($urandom);
      end
      if ($urandom % 2 == 1) begin
        complete_mem_valid = 1'b1;
        ROB_entries_in[9:5] = (q.size() > 0 && $urandom % 4 != 0) ?
                              5'(q[$urandom % q.size()].idx) : 5'($urandom);
      end
      if ($urandom % 3 == 0) begin
        complete_term_valid = 1'b1;
        ROB_entries_in[4:0] = (q.size() > 0 && $urandom % 4 != 0) ?
                              5'(q[$urandom % q.size()].idx) : 5'($urandom);
        complete_term_failed = ($urandom % 10) == 0;
        term_address = 16'($urandom);
      end
      cycle();
    end
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 32, number of ROB entries; power of two; entry index width ROB_W = log2(DEPTH) = 5.
REQ-002 Ports, one per line:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alloc_valid  input  1  rename offers one op.
- alloc_ready  output  1  ROB accepts; transfer when both high.
- alloc_arch_regs  input  8  two 4-bit architectural dests.
- alloc_phys_regs  input  2*PR_ADDR_W  two new physical dests.
- alloc_old_phys  input  2*PR_ADDR_W  previous mappings to free at commit.
- alloc_dest_mask  input  2  which dest slots are live.
- alloc_entry  output  5  index assigned to the offered op (current tail).
- complete_arith_valid, complete_mem_valid  input  1 each  lane completion strobes.
- ROB_entries_in  input  15  lane entries {arith[14:10], mem[9:5], term[4:0]}.
- complete_term_valid  input  1  terminator result offered.
- complete_term_ready  output  1  ROB accepts terminator result.
- complete_term_failed  input  1  terminator mispredicted/redirects.
- term_address  input  16  redirect target.
- commit_valid  output  1  head op retires this cycle.
- commit_arch_regs  output  8; commit_phys_regs  output  2*PR_ADDR_W; commit_free_regs  output  2*PR_ADDR_W; commit_dest_mask  output  2  retiring op's mapping.
- flush  output  1  one-cycle pulse; all younger ops discarded.
- redirect_addr  output  16  fetch target, valid while flush high.

Function
REQ-003 Circular buffer: head, tail (5 bits each, wrap DEPTH-1 -> 0), count (6 bits, 0..32).
REQ-004 Per entry: valid, done, failed, arch/phys/old-phys/mask fields, 16-bit address.
REQ-005 alloc_ready = (count != DEPTH) and not flush; capacity freed by a same-cycle commit is not counted.
REQ-006 On alloc transfer: entry[tail] written valid=1, done=0, failed=0; tail increments.
REQ-007 alloc_entry equals tail combinationally, also when alloc_valid is low.
REQ-008 Arith/mem strobe sets done on the addressed entry next edge; strobe to an invalid entry is ignored.
REQ-009 complete_term_ready = not flush; on transfer: done=1, failed=complete_term_failed, address=term_address.
REQ-010 All three lanes may complete distinct entries in the same cycle; all take effect.
REQ-011 Commit condition: count != 0 and entry[head].valid and entry[head].done; then commit_valid=1 combinationally from registered state, head increments, entry cleared.
REQ-012 At most one commit per cycle; no back-pressure on commit outputs.
REQ-013 Earliest commit: cycle after the completion edge (done registered; no same-cycle bypass).
REQ-014 commit_* data outputs are zero whenever commit_valid is low.
REQ-015 Failed terminator at head: committed normally (commit_valid=1) and, in the same cycle, flush=1 and redirect_addr=its address.
REQ-016 Flush effect at that edge: every entry invalidated, tail=head+1, count=0; an alloc offered that cycle is not accepted.
REQ-017 Alloc and commit in the same cycle: count unchanged; simultaneous alloc and flush: flush wins.
REQ-018 Completions arriving in the flush cycle for younger entries are discarded.

Reset
REQ-019 On rst: head=tail=0, count=0, all valid/done/failed cleared; outputs next cycle: alloc_ready=1, alloc_entry=0, commit_valid=0, flush=0, redirect_addr=0, complete_term_ready=1.
REQ-020 rst mid-operation discards all in-flight entries without emitting commit or flush.

Structure
REQ-021 PR_ADDR_W, ROB_W, DEPTH and the renamed-op field offsets live in the shared constants header.
REQ-022 One natural sub-module: rob_ptr, a wrapping pointer/counter pair (head, tail, count) with inc/flush controls.

Verification
REQ-023 Reset, alloc 3 ops (entries 0,1,2), complete 2,1,0 -> commits in order 0,1,2 on consecutive cycles, none before entry 0 done.
REQ-024 Alloc 32 ops without completion -> alloc_ready low at count=32; complete+commit entry 0 -> alloc_ready high next cycle, next alloc_entry=0 (wrap).
REQ-025 Arith, mem, term strobes to entries 4,5,6 in one cycle -> all three done; 4,5,6 commit on successive cycles once head reaches 4.
REQ-026 Ops 0..5 allocated, term at 2 completes failed with address 16'hC000 -> 0,1 commit, then commit of 2 with flush=1, redirect_addr=16'hC000; entries 3..5 never commit; next alloc_entry=3.
REQ-027 Completion strobe to an unallocated entry 9 -> no state change; later alloc of 9 still requires its own completion.
REQ-028 Assert rst with 10 entries in flight -> no commit_valid or flush afterwards, count=0, alloc_entry=0.
